// File: rtl/sys_peripheral_bridge.sv
// Single-word request-to-strobe bridge for the system-peripheral bus on hb_clk.
// sys_share = {raddr, waddr, wdata}; sel[2k] = slot k ren, sel[2k+1] = slot k wen; periph_rdata[32k +: 32] = slot k.
module sys_peripheral_bridge #(
  parameter int NUM_PERIPH = 4,
  parameter int REG_ADDR_W = 2,
  parameter int ADDR_W     = 8
) (
  input  logic                        hb_clk,
  input  logic                        rst_n,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic                        req_we,
  input  logic [ADDR_W-1:0]           req_addr,
  input  logic [31:0]                 req_wdata,
  output logic                        resp_valid,
  input  logic                        resp_ready,
  output logic [31:0]                 resp_rdata,
  output logic                        resp_err,
  output logic [2*REG_ADDR_W+31:0]    sys_share,
  output logic [2*NUM_PERIPH-1:0]     sel,
  input  logic [32*NUM_PERIPH-1:0]    periph_rdata
);

  localparam int SLOT_W = (NUM_PERIPH > 1) ? $clog2(NUM_PERIPH) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT_RD, RESP} state_t;

  state_t                  r_state;
  logic                    r_we;
  logic                    r_err;
  logic [SLOT_W-1:0]       r_slot;
  logic [REG_ADDR_W-1:0]   r_raddr;
  logic [REG_ADDR_W-1:0]   r_waddr;
  logic [31:0]             r_wdata;
  logic [2*NUM_PERIPH-1:0] r_sel;
  logic                    r_resp_valid;
  logic                    r_resp_err;
  logic [31:0]             r_resp_rdata;

  logic [SLOT_W-1:0]       w_slot;
  logic [REG_ADDR_W-1:0]   w_reg;
  logic                    w_err;
  logic [2*NUM_PERIPH-1:0] w_sel_dec;
  logic [31:0]             w_slot_rdata;

  assign w_reg  = req_addr[REG_ADDR_W-1:0];
  assign w_slot = req_addr[REG_ADDR_W +: SLOT_W];
  // Out-of-range slot or any address bit above the slot field is a decode error.
  assign w_err  = (32'(w_slot) >= 32'(NUM_PERIPH)) ||
                  ((req_addr >> (REG_ADDR_W + SLOT_W)) != '0);

  always_comb begin
    w_sel_dec    = '0;
    w_slot_rdata = '0;
    for (int k = 0; k < NUM_PERIPH; k++) begin
      if (w_slot == SLOT_W'(k) && !w_err) begin
        w_sel_dec[2*k]   = !req_we;
        w_sel_dec[2*k+1] = req_we;
      end
      if (r_slot == SLOT_W'(k)) begin
        w_slot_rdata = periph_rdata[32*k +: 32];
      end
    end
  end

  always_ff @(posedge hb_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_we         <= 1'b0;
      r_err        <= 1'b0;
      r_slot       <= '0;
      r_raddr      <= '0;
      r_waddr      <= '0;
      r_wdata      <= '0;
      r_sel        <= '0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_we    <= req_we;
            r_slot  <= w_slot;
            r_err   <= w_err;
            r_sel   <= w_sel_dec;
            if (req_we) begin
              r_waddr <= w_reg;
              r_wdata <= req_wdata;
            end else begin
              r_raddr <= w_reg;
            end
            r_state <= ACCESS;
          end
        end
        ACCESS: begin
          r_sel <= '0;
          if (!r_we && !r_err) begin
            r_state <= WAIT_RD;
          end else begin
            r_resp_rdata <= '0;
            r_resp_err   <= r_err;
            r_resp_valid <= 1'b1;
            r_state      <= RESP;
          end
        end
        // Responder registered its data on the strobe edge; take it now.
        WAIT_RD: begin
          r_resp_rdata <= w_slot_rdata;
          r_resp_err   <= 1'b0;
          r_resp_valid <= 1'b1;
          r_state      <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_state      <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready  = (r_state == IDLE);
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign resp_err   = r_resp_err;
  assign sys_share  = {r_raddr, r_waddr, r_wdata};
  assign sel        = r_sel;

endmodule

// File: tb/tb_sys_peripheral_bridge.sv
// Bench for sys_peripheral_bridge: transaction-level model checked every cycle plus directed literal checks.
module tb_sys_peripheral_bridge;

  localparam int NP = 3;

  logic        hb_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [7:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [35:0] sys_share;
  logic [5:0]  sel;
  logic [95:0] periph_rdata;

  int total = 0;
  int bad = 0;

  sys_peripheral_bridge #(.NUM_PERIPH(NP), .REG_ADDR_W(2), .ADDR_W(8)) dut (
    .hb_clk(hb_clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .sys_share(sys_share), .sel(sel), .periph_rdata(periph_rdata)
  );

  always #5 hb_clk = ~hb_clk;

  // Register-file responders: write on wen, register read data on ren.
  logic [31:0] rf [NP][4];
  logic [31:0] prd [NP];
  always @(posedge hb_clk) begin
    for (int k = 0; k < NP; k++) begin
      if (sel[2*k])   prd[k] <= rf[k][sys_share[35:34]];
      if (sel[2*k+1]) rf[k][sys_share[33:32]] <= sys_share[31:0];
    end
  end
  assign periph_rdata = {prd[2], prd[1], prd[0]};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Transaction model: one outstanding request, fixed latencies, flat word memory.
  int          cyc = 0;
  bit          m_out = 1'b0;
  int          m_acc = 0;
  int          m_lat = 1;
  bit          m_we = 1'b0;
  bit          m_err = 1'b0;
  int          m_slot = 0;
  logic [1:0]  m_raddr = '0;
  logic [1:0]  m_waddr = '0;
  logic [31:0] m_wdata = '0;
  logic [31:0] m_rdata = '0;
  logic [31:0] m_mem [256];
  int          last_strobe = -1;
  logic [5:0]  exp_sel;
  bit          exp_rv;

  initial forever begin
    @(posedge hb_clk or negedge rst_n);
    if (!rst_n) begin
      m_out   = 1'b0;
      m_raddr = '0;
      m_waddr = '0;
      m_wdata = '0;
    end else begin
      if (m_out && cyc >= m_acc + m_lat && resp_ready) begin
        m_out = 1'b0;
      end else if (!m_out && req_valid) begin
        m_out  = 1'b1;
        m_acc  = cyc + 1;
        m_we   = req_we;
        m_slot = int'(req_addr[7:2]);
        m_err  = (m_slot >= NP);
        if (req_we) begin
          m_waddr = req_addr[1:0];
          m_wdata = req_wdata;
          if (!m_err) m_mem[req_addr] = req_wdata;
        end else begin
          m_raddr = req_addr[1:0];
        end
        m_rdata = (m_we || m_err) ? 32'h0 : m_mem[req_addr];
        m_lat   = (!m_we && !m_err) ? 2 : 1;
      end
      cyc++;
    end
  end

  initial forever begin
    @(negedge hb_clk);
    exp_sel = '0;
    if (m_out && cyc == m_acc && !m_err) exp_sel[2*m_slot + int'(m_we)] = 1'b1;
    exp_rv = m_out && (cyc >= m_acc + m_lat);
    check("cyc_sel", 64'(sel), 64'(exp_sel));
    check("cyc_resp_valid", 64'(resp_valid), 64'(exp_rv));
    if (exp_rv) begin
      check("cyc_resp_rdata", 64'(resp_rdata), 64'(m_rdata));
      check("cyc_resp_err", 64'(resp_err), 64'(m_err));
    end
    check("cyc_req_ready", 64'(req_ready), 64'(!m_out));
    check("cyc_sys_share", 64'(sys_share), 64'({m_raddr, m_waddr, m_wdata}));
    if (!rst_n) begin
      check("cyc_rst_rdata", 64'(resp_rdata), 64'h0);
      check("cyc_rst_err", 64'(resp_err), 64'h0);
    end
    if (sel != '0) begin
      if (last_strobe >= 0) check("strobe_gap", 64'(cyc - last_strobe >= 2), 64'h1);
      last_strobe = cyc;
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge hb_clk);
    while (!req_ready && n < 40) begin
      @(negedge hb_clk);
      n++;
    end
    if (!req_ready) begin
      total++;
      bad++;
      $display("FAIL idle_timeout: req_ready stuck at %0b, expected 1", req_ready);
    end
  endtask

  task automatic wait_resp();
    int n = 0;
    while (!resp_valid && n < 40) begin
      @(negedge hb_clk);
      n++;
    end
    if (!resp_valid) begin
      total++;
      bad++;
      $display("FAIL resp_timeout: resp_valid stuck at %0b, expected 1", resp_valid);
    end
  endtask

  // Presents one request while idle; returns #1 after the acceptance edge.
  task automatic issue(input logic we, input logic [7:0] addr, input logic [31:0] wd);
    @(posedge hb_clk); #1;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wd;
    @(posedge hb_clk); #1;
    req_valid = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge hb_clk);
    #1;
    check("rst_resp_valid", 64'(resp_valid), 64'h0);
    check("rst_sel", 64'(sel), 64'h0);
    check("rst_share", 64'(sys_share), 64'h0);
    check("rst_req_ready", 64'(req_ready), 64'h1);
    rst_n = 1'b1;

    wait_idle();
    issue(1'b1, 8'h02, 32'h0000_0010);
    check("wr_sel", 64'(sel), 64'h02);
    check("wr_share", 64'(sys_share), 64'h2_0000_0010);
    @(posedge hb_clk); #1;
    check("wr_resp_valid", 64'(resp_valid), 64'h1);
    check("wr_resp_err", 64'(resp_err), 64'h0);
    check("wr_resp_rdata", 64'(resp_rdata), 64'h0);

    wait_idle();
    issue(1'b1, 8'h07, 32'hDEAD_BEEF);
    wait_idle();
    issue(1'b0, 8'h07, 32'h0);
    check("rd_sel", 64'(sel), 64'h04);
    check("rd_share", 64'(sys_share), 64'hF_DEAD_BEEF);
    @(posedge hb_clk); #1;
    check("rd_early_valid", 64'(resp_valid), 64'h0);
    check("rd_early_sel", 64'(sel), 64'h0);
    @(posedge hb_clk); #1;
    check("rd_resp_valid", 64'(resp_valid), 64'h1);
    check("rd_resp_rdata", 64'(resp_rdata), 64'hDEAD_BEEF);

    wait_idle();
    issue(1'b0, 8'h10, 32'h0);
    check("err_hi_sel", 64'(sel), 64'h0);
    @(posedge hb_clk); #1;
    check("err_hi_valid", 64'(resp_valid), 64'h1);
    check("err_hi_err", 64'(resp_err), 64'h1);
    check("err_hi_rdata", 64'(resp_rdata), 64'h0);

    wait_idle();
    issue(1'b0, 8'h0C, 32'h0);
    check("err_slot_sel", 64'(sel), 64'h0);
    @(posedge hb_clk); #1;
    check("err_slot_valid", 64'(resp_valid), 64'h1);
    check("err_slot_err", 64'(resp_err), 64'h1);
    wait_idle();
    issue(1'b1, 8'h0D, 32'h5555_AAAA);
    check("err_wr_sel", 64'(sel), 64'h0);

    wait_idle();
    resp_ready = 1'b0;
    issue(1'b0, 8'h07, 32'h0);
    wait_resp();
    for (int i = 0; i < 5; i++) begin
      @(negedge hb_clk);
      check("bp_valid", 64'(resp_valid), 64'h1);
      check("bp_rdata", 64'(resp_rdata), 64'hDEAD_BEEF);
      check("bp_req_ready", 64'(req_ready), 64'h0);
      check("bp_sel", 64'(sel), 64'h0);
    end
    @(posedge hb_clk); #1;
    resp_ready = 1'b1;
    @(posedge hb_clk); #1;
    check("bp_after_ready", 64'(req_ready), 64'h1);
    check("bp_after_valid", 64'(resp_valid), 64'h0);

    wait_idle();
    issue(1'b1, 8'h00, 32'h1234_5678);
    wait_idle();
    issue(1'b0, 8'h00, 32'h0);
    check("b2b_sel", 64'(sel), 64'h01);
    @(posedge hb_clk); #1;
    @(posedge hb_clk); #1;
    check("b2b_rdata", 64'(resp_rdata), 64'h1234_5678);

    wait_idle();
    issue(1'b0, 8'h07, 32'h0);
    @(posedge hb_clk); #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_sel", 64'(sel), 64'h0);
    check("mid_rst_valid", 64'(resp_valid), 64'h0);
    check("mid_rst_rdata", 64'(resp_rdata), 64'h0);
    check("mid_rst_err", 64'(resp_err), 64'h0);
    check("mid_rst_share", 64'(sys_share), 64'h0);
    check("mid_rst_ready", 64'(req_ready), 64'h1);
    repeat (2) @(posedge hb_clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge hb_clk);
      check("post_rst_no_resp", 64'(resp_valid), 64'h0);
    end
    wait_idle();
    issue(1'b1, 8'h05, 32'hCAFE_F00D);
    wait_idle();
    issue(1'b0, 8'h05, 32'h0);
    @(posedge hb_clk); #1;
    @(posedge hb_clk); #1;
    check("post_rst_valid", 64'(resp_valid), 64'h1);
    check("post_rst_rdata", 64'(resp_rdata), 64'hCAFE_F00D);

    repeat (3) @(posedge hb_clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sys_peripheral_bridge.md
# sys_peripheral_bridge

Initiator side of the system-peripheral bus. It takes single word requests from the high-speed bus master (core load/store path) and turns each one into a one-cycle `sel[k].ren`/`sel[k].wen` strobe plus broadcast `sys_share` fields. It then collects the responder's registered `rdata` and returns one response per request. It sits between the high-speed bus interconnect and the system peripherals (system timer and siblings), all on `hb_clk`.

## Interface
- `NUM_PERIPH`, 4: number of peripheral slots; slot k owns `sel[k]` and `periph_rdata[k]`.
- `REG_ADDR_W`, 2: per-slot register word-address width, which drives `sys_share.raddr/waddr`.
- `ADDR_W`, 8: request word-address width; must be ≥ `REG_ADDR_W + SLOT_W`.
- Derived: `SLOT_W = max(1, $clog2(NUM_PERIPH))`.

Ports:
- `hb_clk`  in  1  sole clock, high-speed bus clock.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  bridge can accept; high only in IDLE.
- `req_we`  in  1  1 = write, 0 = read.
- `req_addr`  in  ADDR_W  word address; `[REG_ADDR_W-1:0]` = register, `[REG_ADDR_W +: SLOT_W]` = slot, upper bits must be 0.
- `req_wdata`  in  32  write data.
- `resp_valid`  out  1  response present.
- `resp_ready`  in  1  master accepts response.
- `resp_rdata`  out  32  read data; 0 for writes and errors.
- `resp_err`  out  1  address decode error.
- `sys_share`  out  sys_peripheral_t  broadcast `raddr`, `waddr`, `wdata`.
- `sel`  out  sel_t [NUM_PERIPH]  per-slot `ren`/`wen` strobes.
- `periph_rdata`  in  32 × NUM_PERIPH  per-slot registered read data.

## Operation
- FSM states: IDLE, ACCESS, WAIT_RD, RESP. Reset state is IDLE.
- **IDLE**
  - `req_ready`=1.
  - On `req_valid`, latch `req_we`, the slot, the register address, and `req_wdata`.
  - Compute `err` = (slot ≥ NUM_PERIPH) or (any `req_addr` bit above slot field ≠ 0).
  - For a write: load `sys_share.waddr` and `sys_share.wdata`.
  - For a read: load `sys_share.raddr`.
  - Go to ACCESS.
- **ACCESS** (exactly 1 cycle)
  - If not `err`, assert `sel[slot].wen` or `sel[slot].ren`.
  - If `err`, assert no strobe.
  - Read without error: go to WAIT_RD.
  - Write, or any error: go to RESP with `resp_rdata`=0 and `resp_err`=`err`.
- **WAIT_RD** (exactly 1 cycle)
  - Capture `periph_rdata[slot]` into `resp_rdata`; `resp_err`=0.
  - Go to RESP.
- **RESP**
  - `resp_valid`=1; `resp_rdata`/`resp_err` held stable.
  - On `resp_ready`, go to IDLE.
- Register outputs:
  - `sys_share.raddr/waddr/wdata` are registered.
  - They change only on request acceptance: a write updates `waddr`/`wdata` only; a read updates `raddr` only.
  - Otherwise they hold their last value.
- Strobes:
  - `sel` outputs are registered.
  - At most one bit of all `ren`/`wen` is high in any cycle.
  - Each strobe lasts exactly one cycle per request.
- Exactly one response per accepted request; requests are never reordered or dropped.
- Reset (async, any state):
  - FSM goes to IDLE immediately.
  - All `sel` bits, `resp_valid`, `resp_err`, `resp_rdata`, and all `sys_share` fields go to 0.
  - An in-flight request is discarded with no response.

## Timing
- Request accepted at edge N (IDLE, `req_valid`).
- Cycle N+1: strobe and `sys_share` valid.
- Write: `resp_valid` rises in cycle N+2. Minimum 3 cycles per write with `resp_ready` tied high.
- Read:
  - Responder registers `rdata` at edge N+1.
  - Bridge captures it at edge N+2.
  - `resp_valid` rises in cycle N+3. Minimum 4 cycles per read.
- Error: `resp_valid` in cycle N+2 with `resp_err`=1 and `resp_rdata`=0.
- `req_ready` is low from N+1 until the cycle after the response handshake.
- A new request can be accepted in the cycle after RESP exits.
- `resp_valid` never drops without `resp_ready`. With `resp_ready` low it holds indefinitely and no further strobes are issued.

## Test plan
- Write slot 0 reg 2 (`req_addr`=0x02), `wdata`=0x0000_0010 → cycle N+1: `sel[0].wen`=1, `waddr`=2, `wdata`=0x10; no other strobe; `resp_valid` in N+2, `resp_err`=0, `resp_rdata`=0.
- Read slot 1 reg 3 (`req_addr`=0x07), model `periph_rdata[1]` registered on `ren` returning 0xDEAD_BEEF → `sel[1].ren`=1 only in N+1, `raddr`=3; `resp_valid` in N+3 with `resp_rdata`=0xDEAD_BEEF.
- Error cases: `req_addr`=0x10 (upper bit set) read, and slot ≥ NUM_PERIPH with `NUM_PERIPH`=3 and `req_addr`=0x0C → no strobe at all, `resp_err`=1, `resp_rdata`=0, `resp_valid` in N+2.
- Backpressure: read with `resp_ready`=0 for 5 cycles → `resp_valid` and `resp_rdata` stable for all 5 cycles, `req_ready`=0, no strobes; handshake on cycle 6, `req_ready`=1 next cycle.
- Back-to-back: write 0x1234_5678 to slot 0 reg 0, then read slot 0 reg 0 with a register-model responder → read returns 0x1234_5678; strobes separated by ≥2 cycles.
- Reset mid-read: drop `rst_n` during WAIT_RD → all outputs 0 asynchronously, no response after release, and the next request completes normally.
